mux2_rr_arbiter: RTL and testbench

Two-input round-robin arbiter that shares one 2:1 multiplexed output channel between requesters A and B. It drives the select (S) of the 2:1 mux, performs valid/ready handshakes on both inputs, and registers the selected word into a one-entry output stage. It sits in front of any single-consumer sink that two producers share.

---
 rtl/mux2_rr_arbiter_if.sv | 26 ++
 rtl/mux2_rr_arbiter.sv | 57 +++++
 tb/tb_mux2_rr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters (A, B), the arbiter and the single output sink.
interface mux2_rr_arbiter_if #(parameter int unsigned WIDTH = 8);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             x_valid;
  logic [WIDTH-1:0] x_data;
  logic             x_src;
  logic             x_ready;

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, x_ready,
    output a_ready, b_ready, sel, x_valid, x_data, x_src
  );

  // Environment side: drives both requesters and the sink.
  modport master (
    output a_valid, a_data, b_valid, b_data, x_ready,
    input  a_ready, b_ready, sel, x_valid, x_data, x_src
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin arbiter feeding a one-entry registered output stage.
// sel/a_ready/b_ready are combinational; x_* come straight from registers.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux2_rr_arbiter_if.slave   bus
);

  logic             w_ld;
  logic             w_sel;
  logic             w_take;

  logic             r_last;
  logic             r_x_valid;
  logic             r_x_src;
  logic [WIDTH-1:0] r_x_data;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_ld  = ~r_x_valid | bus.x_ready;
    w_sel = r_last;
    case ({bus.a_valid, bus.b_valid})
      2'b10:   w_sel = 1'b0;
      2'b01:   w_sel = 1'b1;
      2'b11:   w_sel = ~r_last;
      default: w_sel = r_last;
    endcase
    w_take = w_ld & ~rst & (w_sel ? bus.b_valid : bus.a_valid);
  end

  assign bus.sel     = w_sel;
  assign bus.a_ready = w_ld & ~w_sel & ~rst;
  assign bus.b_ready = w_ld &  w_sel & ~rst;
  assign bus.x_valid = r_x_valid;
  assign bus.x_data  = r_x_data;
  assign bus.x_src   = r_x_src;

  // Output stage and last-served pointer; an idle drain keeps data/src and last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_valid <= 1'b0;
      r_x_data  <= '0;
      r_x_src   <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_take) begin
      r_x_valid <= 1'b1;
      r_x_data  <= w_sel ? bus.b_data : bus.a_data;
      r_x_src   <= w_sel;
      r_last    <= w_sel;
    end else if (w_ld) begin
      r_x_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed literal scenarios followed by random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mux2_rr_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NRAND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the output stage holds and who was served last.
  bit             m_init  = 1'b0;
  bit             m_valid = 1'b0;
  bit [WIDTH-1:0] m_data  = '0;
  bit             m_src   = 1'b0;
  int             m_last  = 1;
  bit             m_a_acc = 1'b0;
  bit             m_b_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Requester index that gets the channel this cycle (0 = A, 1 = B).
  function automatic int winner(input bit av, input bit bv, input int last);
    if (av && bv) return 1 - last;
    if (av)       return 0;
    if (bv)       return 1;
    return last;
  endfunction

  // Advance the model on each edge using the inputs presented during the cycle.
  always @(posedge clk) begin : model_upd
    bit ld;
    int w;
    ld = !m_valid || bus.x_ready;
    w  = winner(bus.a_valid, bus.b_valid, m_last);
    m_a_acc = 1'b0;
    m_b_acc = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 1'b0;
      m_last  = 1;
    end else if (ld) begin
      if (w == 0 && bus.a_valid) begin
        m_a_acc = 1'b1;
        m_valid = 1'b1;
        m_data  = bus.a_data;
        m_src   = 1'b0;
        m_last  = 0;
      end else if (w == 1 && bus.b_valid) begin
        m_b_acc = 1'b1;
        m_valid = 1'b1;
        m_data  = bus.b_data;
        m_src   = 1'b1;
        m_last  = 1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_init = 1'b1;
  end

  // Compare every DUT output to the model mid-cycle.
  always @(negedge clk) begin : compare
    bit ld;
    int w;
    if (m_init) begin
      ld = !m_valid || bus.x_ready;
      w  = winner(bus.a_valid, bus.b_valid, m_last);
      chk("sel",     32'(bus.sel),     32'(w));
      chk("a_ready", 32'(bus.a_ready), 32'(!rst && ld && w == 0));
      chk("b_ready", 32'(bus.b_ready), 32'(!rst && ld && w == 1));
      chk("x_valid", 32'(bus.x_valid), 32'(m_valid));
      chk("x_data",  32'(bus.x_data),  32'(m_data));
      chk("x_src",   32'(bus.x_src),   32'(m_src));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [WIDTH-1:0] ad,
                       input bit bv, input logic [WIDTH-1:0] bd, input bit xr);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.x_ready = xr;
  endtask

  initial begin
    drive(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);

    // Reset held with both requesting: nothing handshakes.
    repeat (3) begin
      step();
      @(negedge clk);
      chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
      chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant_a", 32'(bus.a_ready), 32'd1);

    // Continuous contention alternates A, B, A, ...
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("alt_data", 32'(bus.x_data), (i % 2 == 0) ? 32'hAA : 32'h55);
      chk("alt_src",  32'(bus.x_src),  32'(i % 2));
    end

    // Lone A word, one-cycle latency.
    step();
    drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("single_a_ready", 32'(bus.a_ready), 32'd1);
    step();
    drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
    @(negedge clk);
    chk("single_a_data", 32'(bus.x_data), 32'h3C);
    chk("single_a_src",  32'(bus.x_src),  32'd0);
    chk("drain_load_b",  32'(bus.b_ready), 32'd1);

    // Backpressure holds B's word while A waits.
    step();
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("bp_data",    32'(bus.x_data),  32'h11);
    chk("bp_src",     32'(bus.x_src),   32'd1);
    chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
    repeat (2) begin
      step();
      @(negedge clk);
      chk("bp_data",    32'(bus.x_data),  32'h11);
      chk("bp_src",     32'(bus.x_src),   32'd1);
      chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
    end
    step();
    bus.x_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_a_ready", 32'(bus.a_ready), 32'd1);
    step();
    @(negedge clk);
    chk("bp_release_data",  32'(bus.x_data),  32'h77);
    chk("bp_release_valid", 32'(bus.x_valid), 32'd1);

    // Reset while FULL discards the word and re-arms A priority.
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_ready", 32'(bus.a_ready), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    chk("midrst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("midrst_x_data",  32'(bus.x_data),  32'd0);
    chk("midrst_grant_a", 32'(bus.a_ready), 32'd1);

    // Idle cycles must not move the last-served pointer.
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("idle_data", 32'(bus.x_data), 32'hAA);
    step();
    step();
    @(negedge clk);
    chk("idle_x_valid", 32'(bus.x_valid), 32'd0);
    chk("idle_hold_data", 32'(bus.x_data), 32'hAA);
    step();
    drive(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    chk("idle_grant_b", 32'(bus.b_ready), 32'd1);
    chk("idle_sel_b",   32'(bus.sel),     32'd1);
    step();
    @(negedge clk);
    chk("idle_b_src", 32'(bus.x_src), 32'd1);

    // Random traffic; a pending request keeps its word until accepted.
    for (int n = 0; n < NRAND; n++) begin
      step();
      rst = ($urandom_range(0, 79) == 0);
      if (!bus.a_valid || m_a_acc) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_data  = WIDTH'($urandom);
      end
      if (!bus.b_valid || m_b_acc) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_data  = WIDTH'($urandom);
      end
      bus.x_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
